// File: rtl/dd_pkg.sv
// Shared definitions for the dark-block mixer.
// Mode encodings and the RGB channel width.
package dd_pkg;

    localparam int CH_W = 8;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_DARK   = 2'd1;
    localparam logic [1:0] MODE_ALL    = 2'd2;
    localparam logic [1:0] MODE_MASK   = 2'd3;

endpackage

// File: rtl/dd_delay.sv
// N-deep shift register with async active-low reset.
// N = 0 collapses to a plain wire.
module dd_delay #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (N == 0) begin : g_wire
            logic unused_clk;
            assign unused_clk = clk_i ^ rst_ni;
            assign q_o = d_i;
        end else begin : g_sr
            logic [W-1:0] sr_q [N];

            // Shift the input down the line each pixel clock.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < N; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
                end
            end

            assign q_o = sr_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/dark_mixer.sv
// Final RGB mixer: inverts pixels of dark blocks with a per-frame fade.
// Timing and data leave LAT+2 cycles after they enter.
module dark_mixer
    import dd_pkg::*;
#(
    parameter int LAT  = 1,
    parameter int FADE = 4,
    parameter int STEP = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                vs_i,
    input  logic                hs_i,
    input  logic                de_i,
    input  logic [3*CH_W-1:0]   data_i,
    input  logic                rx_i,
    input  logic [1:0]          mode_i,
    output logic                vs_o,
    output logic                hs_o,
    output logic                de_o,
    output logic [3*CH_W-1:0]   data_o,
    output logic [FADE:0]       alpha_o
);

    localparam int AW = FADE + 1;
    localparam int MW = CH_W + FADE + 1;
    localparam int BW = 3 + 3 * CH_W;
    localparam logic [AW:0] AMAX   = (AW+1)'(2 ** FADE);
    localparam logic [AW:0] STEP_X = (AW+1)'(STEP);

    // Blend one channel: (v*a + o*(2**FADE-a)) >> FADE, truncated.
    function automatic logic [CH_W-1:0] mix_ch(
        input logic [CH_W-1:0] o,
        input logic [CH_W-1:0] v,
        input logic [AW-1:0]   a
    );
        logic [MW-1:0] acc;
        acc = MW'(v) * MW'(a) + MW'(o) * (MW'(AMAX) - MW'(a));
        return acc[FADE +: CH_W];
    endfunction

    // Stage A: align pixel and timing with the late rx_i flag.
    logic [BW-1:0] a_bus;
    logic          a_vs, a_hs, a_de;
    logic [3*CH_W-1:0] a_data;

    dd_delay #(.W(BW), .N(LAT)) u_stage_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({vs_i, hs_i, de_i, data_i}),
        .q_o    (a_bus)
    );

    assign {a_vs, a_hs, a_de, a_data} = a_bus;

    // Frame control state.
    logic          vs_r_q;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] alpha_q, alpha_d;
    logic [AW:0]   sum;

    // Latch mode and step alpha on each vs rising edge.
    always_comb begin
        mode_d  = mode_q;
        alpha_d = alpha_q;
        sum     = {1'b0, alpha_q} + STEP_X;
        if (vs_i && !vs_r_q) begin
            mode_d = mode_i;
            if (mode_i != MODE_BYPASS) begin
                alpha_d = (sum > AMAX) ? AMAX[AW-1:0] : sum[AW-1:0];
            end else begin
                alpha_d = ({1'b0, alpha_q} < STEP_X) ? '0
                        : alpha_q - STEP_X[AW-1:0];
            end
        end
    end

    // Frame control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_r_q  <= 1'b0;
            mode_q  <= MODE_BYPASS;
            alpha_q <= '0;
        end else begin
            vs_r_q  <= vs_i;
            mode_q  <= mode_d;
            alpha_q <= alpha_d;
        end
    end

    // Stage B: per-pixel select decision.
    logic              sel_d;
    logic              sel_b_q, mask_b_q;
    logic [2:0]        tim_b_q;
    logic [3*CH_W-1:0] orig_b_q, inv_b_q;
    logic [AW-1:0]     alpha_b_q;

    assign sel_d = (mode_q == MODE_ALL)
                 | (((mode_q == MODE_DARK) | (mode_q == MODE_MASK)) & rx_i);

    // Stage B registers: pixel, its inverse, select and timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_b_q   <= 1'b0;
            mask_b_q  <= 1'b0;
            tim_b_q   <= '0;
            orig_b_q  <= '0;
            inv_b_q   <= '0;
            alpha_b_q <= '0;
        end else begin
            sel_b_q   <= sel_d;
            mask_b_q  <= (mode_q == MODE_MASK);
            tim_b_q   <= {a_vs, a_hs, a_de};
            orig_b_q  <= a_data;
            inv_b_q   <= ~a_data;
            alpha_b_q <= alpha_q;
        end
    end

    // Stage C: mix, mask and blank.
    logic [3*CH_W-1:0] mix_d;
    logic [3*CH_W-1:0] data_c_q;
    logic [2:0]        tim_c_q;

    // Choose between original, blended, mask and blank.
    always_comb begin
        mix_d = orig_b_q;
        if (!tim_b_q[0]) begin
            mix_d = '0;
        end else if (mask_b_q) begin
            mix_d = sel_b_q ? '1 : '0;
        end else if (sel_b_q) begin
            for (int c = 0; c < 3; c++) begin
                mix_d[c*CH_W +: CH_W] = mix_ch(orig_b_q[c*CH_W +: CH_W],
                                               inv_b_q[c*CH_W +: CH_W],
                                               alpha_b_q);
            end
        end
    end

    // Stage C output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_c_q <= '0;
            tim_c_q  <= '0;
        end else begin
            data_c_q <= mix_d;
            tim_c_q  <= tim_b_q;
        end
    end

    assign {vs_o, hs_o, de_o} = tim_c_q;
    assign data_o  = data_c_q;
    assign alpha_o = alpha_q;

endmodule
